// File: rtl/rosc_odometer_seq.sv
// rtl/rosc_odometer_seq.sv - command-driven ROSC odometer measure/stress sequencer
module rosc_odometer_seq #(
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_mode,
    input  logic [CH_W-1:0]   i_cmd_ch,
    input  logic              i_cmd_ac_dc,
    input  logic [WIN_W-1:0]  i_cmd_win,
    input  logic              i_stop,
    input  logic              i_rosc_out,
    output logic [NUM_CH-1:0] o_sel,
    output logic              o_en_power_rosc,
    output logic              o_en_rosc,
    output logic              o_meas_stress,
    output logic              o_start,
    output logic              o_ac_dc,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CNT_W-1:0]  o_res_data,
    output logic [CH_W-1:0]   o_res_ch,
    output logic              o_res_ovf,
    output logic              o_res_abort,
    output logic              o_busy
);

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_RESULT,
        S_STRESS
    } state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [WIN_W-1:0]    r_win_last;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [ST_W-1:0]     r_settle_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;

    logic                w_rise;
    logic                w_sat;
    logic                w_ch_ok;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_ovf_next;
    logic [NUM_CH-1:0]   w_sel_cmd;
    logic [WIN_W-1:0]    w_win_last;

    // Rising edge of the synchronised oscillator; saturating edge counter next value
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_sat      = &r_cnt;
    assign w_cnt_next = (w_rise && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_ovf_next = r_ovf | (w_rise & w_sat);
    assign w_ch_ok    = int'(i_cmd_ch) < NUM_CH;
    assign w_sel_cmd  = NUM_CH'(1) << i_cmd_ch;
    // A zero-length window behaves as a one-cycle window
    assign w_win_last = (i_cmd_win == '0) ? '0 : i_cmd_win - WIN_W'(1);

    // Two-flop synchroniser plus previous-sample flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_rosc_out;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Sequencer FSM; every control output is registered on the transition into its state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_ch            <= '0;
            r_win_last      <= '0;
            r_win_cnt       <= '0;
            r_settle_cnt    <= '0;
            r_cnt           <= '0;
            r_ovf           <= 1'b0;
            o_cmd_ready     <= 1'b1;
            o_sel           <= '0;
            o_en_power_rosc <= 1'b0;
            o_en_rosc       <= 1'b0;
            o_meas_stress   <= 1'b0;
            o_start         <= 1'b0;
            o_ac_dc         <= 1'b0;
            o_res_valid     <= 1'b0;
            o_res_data      <= '0;
            o_res_ch        <= '0;
            o_res_ovf       <= 1'b0;
            o_res_abort     <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        r_ch       <= i_cmd_ch;
                        r_win_last <= w_win_last;
                        // Out-of-range channels are swallowed without leaving IDLE
                        if (w_ch_ok) begin
                            o_sel           <= w_sel_cmd;
                            o_en_power_rosc <= 1'b1;
                            o_cmd_ready     <= 1'b0;
                            o_busy          <= 1'b1;
                            r_settle_cnt    <= '0;
                            r_cnt           <= '0;
                            r_ovf           <= 1'b0;
                            if (i_cmd_mode) begin
                                r_state <= S_STRESS;
                                o_start <= 1'b1;
                                o_ac_dc <= i_cmd_ac_dc;
                            end else begin
                                r_state       <= S_SETTLE;
                                o_en_rosc     <= 1'b1;
                                o_meas_stress <= 1'b1;
                            end
                        end
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + ST_W'(1);
                    if (i_stop) begin
                        r_state         <= S_RESULT;
                        o_sel           <= '0;
                        o_en_power_rosc <= 1'b0;
                        o_en_rosc       <= 1'b0;
                        o_meas_stress   <= 1'b0;
                        o_res_valid     <= 1'b1;
                        o_res_data      <= '0;
                        o_res_ch        <= r_ch;
                        o_res_ovf       <= 1'b0;
                        o_res_abort     <= 1'b1;
                    end else if (r_settle_cnt == ST_W'(SETTLE_CYC - 1)) begin
                        r_state   <= S_COUNT;
                        r_win_cnt <= '0;
                    end
                end
                S_COUNT: begin
                    r_cnt     <= w_cnt_next;
                    r_ovf     <= w_ovf_next;
                    r_win_cnt <= r_win_cnt + WIN_W'(1);
                    // Window expiry and STOP both close the window; the edge of this cycle counts
                    if (i_stop || (r_win_cnt == r_win_last)) begin
                        r_state         <= S_RESULT;
                        o_sel           <= '0;
                        o_en_power_rosc <= 1'b0;
                        o_en_rosc       <= 1'b0;
                        o_meas_stress   <= 1'b0;
                        o_res_valid     <= 1'b1;
                        o_res_data      <= w_cnt_next;
                        o_res_ch        <= r_ch;
                        o_res_ovf       <= w_ovf_next;
                        o_res_abort     <= i_stop;
                    end
                end
                S_RESULT: begin
                    if (i_res_ready) begin
                        r_state     <= S_IDLE;
                        o_res_valid <= 1'b0;
                        o_res_data  <= '0;
                        o_res_ch    <= '0;
                        o_res_ovf   <= 1'b0;
                        o_res_abort <= 1'b0;
                        o_busy      <= 1'b0;
                        o_cmd_ready <= 1'b1;
                    end
                end
                S_STRESS: begin
                    if (i_stop) begin
                        r_state         <= S_IDLE;
                        o_sel           <= '0;
                        o_en_power_rosc <= 1'b0;
                        o_start         <= 1'b0;
                        o_ac_dc         <= 1'b0;
                        o_busy          <= 1'b0;
                        o_cmd_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rosc_odometer_seq.sv
// tb/tb_rosc_odometer_seq.sv - scoreboard bench for rosc_odometer_seq
module tb_rosc_odometer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_mode;
    logic [3:0]  cmd_ch;
    logic        cmd_ac_dc;
    logic [15:0] cmd_win;
    logic        stop;
    logic        rosc;
    logic        res_ready;

    logic        cmd_ready, en_power, en_rosc, meas, start, ac_dc, res_valid, res_ovf, res_abort, busy;
    logic [2:0]  sel;
    logic [15:0] res_data;
    logic [3:0]  res_ch;

    logic        s_cmd_ready, s_en_power, s_en_rosc, s_meas, s_start, s_ac_dc, s_res_valid, s_res_ovf, s_res_abort, s_busy;
    logic [2:0]  s_sel;
    logic [3:0]  s_res_data;
    logic [3:0]  s_res_ch;

    logic [12:0] ctl;
    assign ctl = {sel, en_power, en_rosc, meas, start, ac_dc, res_valid, res_ovf, res_abort, busy, cmd_ready};

    localparam logic [12:0] CTL_IDLE = 13'b000_0_0_0_0_0_0_0_0_0_1;

    typedef struct {
        logic [3:0] ch;
        int         lo;
        int         hi;
        logic       ovf;
        logic       abort;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rosc_half = 0;
    int   cyc;
    int   held_data;

    rosc_odometer_seq u_dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_mode(cmd_mode), .i_cmd_ch(cmd_ch), .i_cmd_ac_dc(cmd_ac_dc), .i_cmd_win(cmd_win),
        .i_stop(stop), .i_rosc_out(rosc), .o_sel(sel), .o_en_power_rosc(en_power),
        .o_en_rosc(en_rosc), .o_meas_stress(meas), .o_start(start), .o_ac_dc(ac_dc),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_res_ch(res_ch), .o_res_ovf(res_ovf), .o_res_abort(res_abort), .o_busy(busy)
    );

    rosc_odometer_seq #(.CNT_W(4)) u_dut_ovf (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(s_cmd_ready),
        .i_cmd_mode(cmd_mode), .i_cmd_ch(cmd_ch), .i_cmd_ac_dc(cmd_ac_dc), .i_cmd_win(cmd_win),
        .i_stop(stop), .i_rosc_out(rosc), .o_sel(s_sel), .o_en_power_rosc(s_en_power),
        .o_en_rosc(s_en_rosc), .o_meas_stress(s_meas), .o_start(s_start), .o_ac_dc(s_ac_dc),
        .o_res_valid(s_res_valid), .i_res_ready(res_ready), .o_res_data(s_res_data),
        .o_res_ch(s_res_ch), .o_res_ovf(s_res_ovf), .o_res_abort(s_res_abort), .o_busy(s_busy)
    );

    always #5 clk = ~clk;

    // Oscillator model: toggles 2 ns before CLK rising edges, never on them
    initial begin
        rosc = 1'b0;
        #3;
        forever begin
            if (rosc_half == 0) begin
                rosc = 1'b0;
                #10;
            end else begin
                #(rosc_half) rosc = ~rosc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic mode, input logic [3:0] ch, input logic acdc, input logic [15:0] win);
        cmd_mode  = mode;
        cmd_ch    = ch;
        cmd_ac_dc = acdc;
        cmd_win   = win;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start_cyc, input int budget, output int got);
        got = start_cyc;
        while (res_valid !== 1'b1 && got < budget) begin
            tick();
            got++;
        end
        if (res_valid !== 1'b1) got = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (ctl !== CTL_IDLE || res_data !== 16'd0 || res_ch !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_state: ctl=%b data=%0d want ctl=%b data=0", ctl, res_data, CTL_IDLE);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_measure();
        rosc_half = 40;
        sb.push_back('{ch: 4'd1, lo: 12, hi: 13, ovf: 1'b0, abort: 1'b0});
        send_cmd(1'b0, 4'd1, 1'b0, 16'd100);
        n_cmp++;
        if (ctl !== 13'b010_1_1_1_0_0_0_0_0_1_0) begin
            n_bad++;
            $display("FAIL measure_settle_outputs: ctl=%b want %b", ctl, 13'b010_1_1_1_0_0_0_0_0_1_0);
        end
        wait_valid(1, 400, cyc);
        n_cmp++;
        if (cyc != 109) begin
            n_bad++;
            $display("FAIL measure_latency: got %0d want 109", cyc);
        end
        e = sb.pop_front();
        n_cmp++;
        if (int'(res_data) < e.lo || int'(res_data) > e.hi || res_ch !== e.ch || res_ovf !== e.ovf || res_abort !== e.abort) begin
            n_bad++;
            $display("FAIL measure_result: data=%0d ch=%0d ovf=%0b abort=%0b want %0d..%0d ch=%0d ovf=%0b abort=%0b",
                     res_data, res_ch, res_ovf, res_abort, e.lo, e.hi, e.ch, e.ovf, e.abort);
        end
        n_cmp++;
        if (ctl !== 13'b000_0_0_0_0_0_1_0_0_1_0) begin
            n_bad++;
            $display("FAIL measure_result_ctl: ctl=%b want %b", ctl, 13'b000_0_0_0_0_0_1_0_0_1_0);
        end
        held_data = int'(res_data);
    endtask

    task automatic test_backpressure();
        int bad_cnt = 0;
        stop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(res_data) != held_data || res_ch !== 4'd1 || res_valid !== 1'b1 || cmd_ready !== 1'b0) bad_cnt++;
        end
        stop = 1'b0;
        n_cmp++;
        if (bad_cnt != 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: unstable cycles %0d want 0", bad_cnt);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (ctl !== CTL_IDLE) begin
            n_bad++;
            $display("FAIL backpressure_release: ctl=%b want %b", ctl, CTL_IDLE);
        end
    endtask

    task automatic test_overflow();
        rosc_half = 20;
        sb.push_back('{ch: 4'd0, lo: 50, hi: 50, ovf: 1'b0, abort: 1'b0});
        send_cmd(1'b0, 4'd0, 1'b0, 16'd200);
        wait_valid(1, 400, cyc);
        n_cmp++;
        if (cyc != 209) begin
            n_bad++;
            $display("FAIL overflow_latency: got %0d want 209", cyc);
        end
        e = sb.pop_front();
        n_cmp++;
        if (int'(res_data) < e.lo || int'(res_data) > e.hi || res_ch !== e.ch || res_ovf !== e.ovf || res_abort !== e.abort) begin
            n_bad++;
            $display("FAIL wide_count: data=%0d ovf=%0b want %0d ovf=%0b", res_data, res_ovf, e.lo, e.ovf);
        end
        n_cmp++;
        if (s_res_valid !== 1'b1 || s_res_data !== 4'd15 || s_res_ovf !== 1'b1 || s_res_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL narrow_saturate: valid=%0b data=%0d ovf=%0b want valid=1 data=15 ovf=1", s_res_valid, s_res_data, s_res_ovf);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        rosc_half = 40;
    endtask

    task automatic test_stress();
        int bad_cnt = 0;
        int seen_valid = 0;
        send_cmd(1'b1, 4'd2, 1'b1, 16'd0);
        for (int i = 0; i < 500; i++) begin
            if (ctl !== 13'b100_1_0_0_1_1_0_0_0_1_0) bad_cnt++;
            tick();
        end
        n_cmp++;
        if (bad_cnt != 0) begin
            n_bad++;
            $display("FAIL stress_outputs: bad cycles %0d want 0 (last ctl=%b)", bad_cnt, ctl);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (ctl !== CTL_IDLE) begin
            n_bad++;
            $display("FAIL stress_stop: ctl=%b want %b", ctl, CTL_IDLE);
        end
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b0) seen_valid++;
            tick();
        end
        n_cmp++;
        if (seen_valid != 0) begin
            n_bad++;
            $display("FAIL stress_no_result: valid cycles %0d want 0", seen_valid);
        end
    endtask

    task automatic test_abort();
        sb.push_back('{ch: 4'd2, lo: 0, hi: 0, ovf: 1'b0, abort: 1'b1});
        send_cmd(1'b0, 4'd2, 1'b0, 16'd100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (res_valid !== 1'b1 || int'(res_data) != e.lo || res_ch !== e.ch || res_abort !== e.abort || res_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL abort_settle: valid=%0b data=%0d ch=%0d abort=%0b want 1 0 %0d 1", res_valid, res_data, res_ch, res_abort, e.ch);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        sb.push_back('{ch: 4'd0, lo: 3, hi: 4, ovf: 1'b0, abort: 1'b1});
        send_cmd(1'b0, 4'd0, 1'b0, 16'd200);
        for (int i = 0; i < 37; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (res_valid !== 1'b1 || int'(res_data) < e.lo || int'(res_data) > e.hi || res_ch !== e.ch || res_abort !== e.abort || res_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL abort_count: valid=%0b data=%0d abort=%0b want 1 %0d..%0d 1", res_valid, res_data, res_abort, e.lo, e.hi);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_bad_channel();
        int bad_cnt = 0;
        send_cmd(1'b0, 4'd5, 1'b0, 16'd10);
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || sel !== 3'b000) bad_cnt++;
            tick();
        end
        n_cmp++;
        if (bad_cnt != 0) begin
            n_bad++;
            $display("FAIL bad_channel: bad cycles %0d want 0", bad_cnt);
        end
    endtask

    task automatic test_stop_at_accept_zero_win();
        rosc_half = 0;
        sb.push_back('{ch: 4'd1, lo: 0, hi: 0, ovf: 1'b0, abort: 1'b0});
        stop = 1'b1;
        send_cmd(1'b0, 4'd1, 1'b0, 16'd0);
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || sel !== 3'b010) begin
            n_bad++;
            $display("FAIL stop_at_accept: busy=%0b sel=%b want 1 010", busy, sel);
        end
        wait_valid(1, 100, cyc);
        n_cmp++;
        if (cyc != 10) begin
            n_bad++;
            $display("FAIL zero_window_latency: got %0d want 10", cyc);
        end
        e = sb.pop_front();
        n_cmp++;
        if (int'(res_data) != e.lo || res_abort !== e.abort || res_ch !== e.ch) begin
            n_bad++;
            $display("FAIL zero_window_result: data=%0d abort=%0b ch=%0d want 0 0 %0d", res_data, res_abort, res_ch, e.ch);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        rosc_half = 40;
    endtask

    task automatic test_reset_mid_count();
        int seen_valid = 0;
        send_cmd(1'b0, 4'd1, 1'b0, 16'd100);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (ctl !== CTL_IDLE || res_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_count: ctl=%b want %b", ctl, CTL_IDLE);
        end
        for (int i = 0; i < 150; i++) begin
            if (res_valid !== 1'b0 || s_res_valid !== 1'b0) seen_valid++;
            tick();
        end
        n_cmp++;
        if (seen_valid != 0) begin
            n_bad++;
            $display("FAIL reset_stale_result: valid cycles %0d want 0", seen_valid);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: left %0d want 0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 1'b0;
        cmd_ch    = 4'd0;
        cmd_ac_dc = 1'b0;
        cmd_win   = 16'd0;
        stop      = 1'b0;
        res_ready = 1'b0;
        #1;
        test_reset();
        test_measure();
        test_backpressure();
        test_overflow();
        test_stress();
        test_abort();
        test_bad_channel();
        test_stop_at_accept_zero_win();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/rosc_odometer_seq.md
Name: rosc_odometer_seq

Overview:
- Sequential measurement/stress controller for an array of NUM_CH ring-oscillator odometer channels.
- Replaces fixed 3-channel combinational select/power gating with a command-driven FSM that:
  - powers and selects one channel;
  - waits a settle time;
  - counts oscillator edges over a programmable window;
  - returns the count through a valid/ready result port.
- Also sequences long AC/DC stress phases.
- Sits between the chip control/scan interface and the ROSC control/power-switch blocks.

Parameters:
- NUM_CH, 3: number of ROSC channels. Range 1..16.
- CH_W, 4: width of the channel index. Must satisfy 2^CH_W >= NUM_CH.
- CNT_W, 16: width of the edge counter and result.
- WIN_W, 16: width of the measurement window length.
- SETTLE_CYC, 8: CLK cycles between power/enable assertion and the start of counting. Must be >= 1.

Ports:
- CLK, in, 1: system clock.
- RST, in, 1: synchronous, active-high reset.
- CMD_VALID, in, 1: command request.
- CMD_READY, out, 1: controller accepts a command. High only in IDLE.
- CMD_MODE, in, 1: 0 = measure, 1 = stress.
- CMD_CH, in, CH_W: target channel index.
- CMD_AC_DC, in, 1: stress type. 1 = AC (external clock), 0 = DC.
- CMD_WIN, in, WIN_W: measurement window in CLK cycles. 0 is treated as 1.
- STOP, in, 1: ends a stress phase or aborts a measurement.
- ROSC_OUT, in, 1: muxed, pre-divided ROSC output. Asynchronous to CLK; its frequency is below CLK/4.
- SEL, out, NUM_CH: one-hot channel select.
- EN_POWER_ROSC, out, 1: virtual-VDD power enable.
- EN_ROSC, out, 1: ring closed (free-running oscillation).
- MEAS_STRESS, out, 1: 1 during measurement.
- START, out, 1: stress clock gate.
- AC_DC, out, 1: latched stress type.
- RES_VALID, out, 1: result available.
- RES_READY, in, 1: result consumer ready.
- RES_DATA, out, CNT_W: edge count.
- RES_CH, out, CH_W: channel of the result.
- RES_OVF, out, 1: counter saturated.
- RES_ABORT, out, 1: measurement ended by STOP.
- BUSY, out, 1: FSM not in IDLE.

Behaviour:
- Reset (RST high at a CLK edge):
  - FSM goes to IDLE.
  - All outputs are 0, except CMD_READY = 1.
  - Counters, synchronizer flops and the latched command are cleared.
  - Reset mid-operation drops power/select the cycle after the reset edge; any pending result is discarded.
- Command handshake:
  - A command is accepted on a CLK edge with CMD_VALID & CMD_READY.
  - CMD_CH, CMD_MODE, CMD_AC_DC and CMD_WIN are latched on acceptance.
  - If CMD_CH >= NUM_CH, the command is accepted but ignored; the FSM stays in IDLE and no result is produced.
- FSM states: IDLE, SETTLE, COUNT, RESULT, STRESS.
- IDLE:
  - Accepted measure command -> SETTLE. Accepted stress command -> STRESS.
  - STOP is ignored in IDLE.
- SETTLE:
  - Outputs: SEL = one-hot(ch), EN_POWER_ROSC = 1, MEAS_STRESS = 1, EN_ROSC = 1.
  - Stays exactly SETTLE_CYC cycles, then -> COUNT.
  - The synchronizer runs during SETTLE, but edges are not counted.
  - STOP -> RESULT with RES_ABORT = 1 and RES_DATA = 0.
- COUNT:
  - Outputs are the same as SETTLE.
  - ROSC_OUT passes through a 2-flop synchronizer and a rising-edge detector (prev-flop compare).
  - Each detected rising edge increments the edge counter.
  - The counter saturates at 2^CNT_W-1 and sets the overflow flag; it never wraps.
  - The window counter runs max(CMD_WIN,1) cycles, then -> RESULT.
  - An edge detected in the final window cycle is counted.
  - STOP -> RESULT immediately with RES_ABORT = 1. RES_DATA holds the partial count.
- RESULT:
  - Outputs: EN_ROSC = 0, EN_POWER_ROSC = 0, MEAS_STRESS = 0, SEL = 0.
  - RES_VALID = 1, with RES_DATA, RES_CH, RES_OVF and RES_ABORT held stable until RES_VALID & RES_READY.
  - On the handshake edge -> IDLE; RES_VALID falls the next cycle.
  - STOP has no effect in RESULT.
- STRESS:
  - Outputs: SEL = one-hot(ch), EN_POWER_ROSC = 1, MEAS_STRESS = 0, EN_ROSC = 0, START = 1, AC_DC = latched value.
  - Stays until STOP, then -> IDLE. No result is produced.
  - CMD_READY = 0 throughout.
- Latency:
  - Command accept to first counted edge window: SETTLE_CYC + 1 cycles.
  - Accept to RES_VALID: 1 + SETTLE_CYC + max(CMD_WIN,1) cycles (non-aborted).
- Simultaneous events:
  - STOP in the same cycle as window expiry is an abort.
  - STOP in the same cycle as command accept is ignored; the command proceeds.
- All control outputs are registered. SEL is never multi-hot.

Test Plan:
- Reset, then measure ch=1, WIN=100, SETTLE_CYC=8, ROSC_OUT period 8 CLK:
  - SEL=3'b010 from the cycle after accept.
  - RES_VALID rises at cycle 109 after accept.
  - RES_DATA=12 or 13, RES_OVF=0, RES_ABORT=0.
- Backpressure: hold RES_READY=0 for 20 cycles after RES_VALID:
  - RES_DATA/RES_CH stay stable and CMD_READY stays 0.
  - Release RES_READY -> IDLE the next cycle and CMD_READY=1.
- Overflow: CNT_W=4, WIN=200, ROSC_OUT period 4:
  - RES_DATA=15, RES_OVF=1.
- Stress: AC stress on ch=2 (CMD_AC_DC=1):
  - SEL=3'b100, START=1, AC_DC=1, MEAS_STRESS=0 for 500 cycles.
  - STOP -> all outputs 0 and CMD_READY=1 the next cycle; no RES_VALID.
- Abort: STOP at COUNT cycle 30 -> RES_ABORT=1 with the partial count.
  - CMD_CH=5 with NUM_CH=3 -> BUSY stays 0 and no result.
- Reset mid-COUNT:
  - All outputs 0 and CMD_READY=1 the cycle after the RST edge; no stale RES_VALID afterwards.
